// File: rtl/psalm_streamer.sv
// Psalm text streamer: walks a BRAM from 0 to MSG_LEN-1, absorbs the one-cycle read latency and
// hands each byte to a UART transmitter over a strobe/busy handshake, pausing between passes.
module psalm_streamer #(
  parameter int unsigned W            = 11,
  parameter int unsigned DW           = 8,
  parameter int unsigned MSG_LEN      = 1481,
  parameter int unsigned PAUSE_CYCLES = 1000000
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  output logic [W-1:0]  o_addr,
  input  logic [DW-1:0] i_mem_data,
  output logic          o_stb,
  output logic [DW-1:0] o_data,
  input  logic          i_busy,
  output logic          o_active,
  output logic          o_done
);

  localparam int unsigned CW = (PAUSE_CYCLES == 0) ? 1 : $clog2(PAUSE_CYCLES + 1);
  localparam logic [W-1:0] LastAddr = W'(MSG_LEN - 1);
  localparam logic [CW-1:0] PauseLoad = (PAUSE_CYCLES == 0) ? '0 : CW'(PAUSE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StSend, StPause} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            stb_q, stb_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    stb_d   = stb_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (i_en) state_d = StFetch;
      end
      // BRAM samples addr_q at the end of this cycle.
      StFetch: state_d = StLoad;
      StLoad: begin
        data_d  = i_mem_data;
        stb_d   = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (!i_busy) begin
          stb_d = 1'b0;
          if (addr_q != LastAddr) begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end else begin
            addr_d = '0;
            done_d = 1'b1;
            if (PAUSE_CYCLES != 0) begin
              cnt_d   = PauseLoad;
              state_d = StPause;
            end else begin
              state_d = i_en ? StFetch : StIdle;
            end
          end
        end
      end
      StPause: begin
        if (cnt_q == '0) state_d = i_en ? StFetch : StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_addr   = addr_q;
  assign o_data   = data_q;
  assign o_stb    = stb_q;
  assign o_done   = done_q;
  assign o_active = (state_q != StIdle);

endmodule

// File: tb/tb_psalm_streamer.sv
// Directed bench for psalm_streamer: a 3-byte/2-pause instance and a 1-byte/no-pause instance,
// each fed by a registered-read ROM model.
module tb_psalm_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, busy, en0, busy0;
  logic [3:0] addr, addr0;
  logic [7:0] mem_data, mem_data0, data, data0;
  logic       stb, stb0, active, active0, done, done0;

  logic [7:0] rom [16];
  logic [7:0] acc_q [$];
  int         done_cnt = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  psalm_streamer #(.W(4), .DW(8), .MSG_LEN(3), .PAUSE_CYCLES(2)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .o_addr(addr), .i_mem_data(mem_data),
    .o_stb(stb), .o_data(data), .i_busy(busy), .o_active(active), .o_done(done)
  );

  psalm_streamer #(.W(4), .DW(8), .MSG_LEN(1), .PAUSE_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en0), .o_addr(addr0), .i_mem_data(mem_data0),
    .o_stb(stb0), .o_data(data0), .i_busy(busy0), .o_active(active0), .o_done(done0)
  );

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hEE;
    rom[0] = 8'h41;
    rom[1] = 8'h42;
    rom[2] = 8'h43;
  end

  always_ff @(posedge clk) begin
    mem_data  <= rom[addr];
    mem_data0 <= rom[addr0];
  end

  // Acceptance is decided by values stable across the negative edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stb && !busy) acc_q.push_back(data);
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    en0   = 1'b0;
    busy  = 1'b0;
    busy0 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int base, base_done, cyc;
    logic exp_stb;
    logic [7:0] exp_data;

    // 1: reset state, latency, done pulse, pause, repeat
    do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_stb", stb, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_active", active, 0);
    rst_n = 1'b1;
    step();
    en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      exp_stb = (k == 3 || k == 6 || k == 9 || k == 14);
      check_eq($sformatf("t1_stb_%0d", k), stb, exp_stb);
      check_eq($sformatf("t1_done_%0d", k), done, (k == 10));
      if (exp_stb) begin
        exp_data = (k == 6) ? 8'h42 : (k == 9) ? 8'h43 : 8'h41;
        check_eq($sformatf("t1_data_%0d", k), data, exp_data);
      end
      if (k == 11) begin
        check_eq("t1_pause_active", active, 1);
        check_eq("t1_pause_addr", addr, 0);
      end
    end

    // 2: busy stall on 0x42
    do_reset();
    base = acc_q.size();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    busy = 1'b1;
    check_eq("t2_stb_6", stb, 1);
    check_eq("t2_data_6", data, 8'h42);
    for (int k = 7; k <= 11; k++) begin
      step();
      check_eq($sformatf("t2_stb_%0d", k), stb, 1);
      check_eq($sformatf("t2_data_%0d", k), data, 8'h42);
      check_eq($sformatf("t2_addr_%0d", k), addr, 1);
    end
    busy = 1'b0;
    step();
    check_eq("t2_stb_12", stb, 0);
    check_eq("t2_addr_12", addr, 2);
    step();
    step();
    check_eq("t2_stb_14", stb, 1);
    check_eq("t2_data_14", data, 8'h43);
    step();
    check_eq("t2_count", acc_q.size() - base, 3);
    if (acc_q.size() - base == 3) begin
      check_eq("t2_b0", acc_q[base], 8'h41);
      check_eq("t2_b1", acc_q[base+1], 8'h42);
      check_eq("t2_b2", acc_q[base+2], 8'h43);
    end

    // 3: one-cycle enable pulse gives exactly one pass
    do_reset();
    base = acc_q.size();
    base_done = done_cnt;
    en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 19; k++) step();
    check_eq("t3_count", acc_q.size() - base, 3);
    if (acc_q.size() - base == 3) begin
      check_eq("t3_b0", acc_q[base], 8'h41);
      check_eq("t3_b1", acc_q[base+1], 8'h42);
      check_eq("t3_b2", acc_q[base+2], 8'h43);
    end
    check_eq("t3_done", done_cnt - base_done, 1);
    check_eq("t3_active", active, 0);
    check_eq("t3_addr", addr, 0);

    // 4: asynchronous reset mid-SEND
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    busy = 1'b1;
    step();
    check_eq("t4_pre_stb", stb, 1);
    check_eq("t4_pre_data", data, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_stb", stb, 0);
    check_eq("t4_addr", addr, 0);
    check_eq("t4_active", active, 0);
    check_eq("t4_data", data, 0);
    #2;
    busy  = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    step();
    check_eq("t4_restart_stb", stb, 1);
    check_eq("t4_restart_data", data, 8'h41);

    // 5: MSG_LEN=1, no pause
    do_reset();
    en0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_stb = (k % 3 == 0);
      check_eq($sformatf("t5_stb_%0d", k), stb0, exp_stb);
      check_eq($sformatf("t5_done_%0d", k), done0, (k % 3 == 1 && k > 1));
      check_eq($sformatf("t5_addr_%0d", k), addr0, 0);
      if (exp_stb) check_eq($sformatf("t5_data_%0d", k), data0, 8'h41);
    end

    // 6: random busy over 100 bytes
    do_reset();
    base = acc_q.size();
    base_done = done_cnt;
    en = 1'b1;
    cyc = 0;
    while (acc_q.size() - base < 100 && cyc < 3000) begin
      step();
      busy = 1'($urandom_range(0, 1));
      cyc++;
    end
    check_eq("t6_count", acc_q.size() - base, 100);
    for (int i = 0; i < 100 && base + i < acc_q.size(); i++)
      check_eq($sformatf("t6_b%0d", i), acc_q[base+i], 8'h41 + 8'(i % 3));
    check_eq("t6_done", done_cnt - base_done, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psalm_streamer.md
Name: psalm_streamer

Overview:
Reader/sequencer for the psalm text BRAM. It walks the stored message from address 0 to MSG_LEN-1 and issues one address per byte. It accounts for the BRAM's one-cycle registered read latency, then presents each byte to the UART transmitter over a strobe/busy handshake. After the last byte it waits a programmable pause and repeats while enabled, replacing ad-hoc address logic in the hello_psalm top level.

Parameters:
W, 11, BRAM address width; must match the memory's W.
DW, 8, data width; must match the memory's DW.
MSG_LEN, 1481, number of bytes sent per pass; legal range 1..(1<<W).
PAUSE_CYCLES, 1000000, idle clocks between passes; 0 means no pause. Counter width is $clog2(PAUSE_CYCLES+1), minimum 1.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_en  input  1  run enable; sampled only in IDLE and at the end of PAUSE.
o_addr  output  W  BRAM read address (tie to the memory i_addr, with i_we=0).
i_mem_data  input  DW  BRAM o_data; valid the cycle after o_addr was sampled.
o_stb  output  1  byte-valid to the UART transmitter.
o_data  output  DW  byte to the transmitter; stable while o_stb=1.
i_busy  input  1  transmitter busy; the byte is accepted on an edge with o_stb=1 and i_busy=0.
o_active  output  1  high in every state except IDLE.
o_done  output  1  one-cycle pulse on acceptance of byte MSG_LEN-1.

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, o_addr=0, o_data=0, o_stb=0, o_done=0, o_active=0, pause counter=0. Takes effect immediately, including mid-byte or mid-pause. No partial byte is held after release.
- States: IDLE, FETCH, LOAD, SEND, PAUSE.
- IDLE: o_addr held at 0. If i_en=1 -> FETCH.
- FETCH (1 cycle): BRAM samples o_addr at the closing edge -> LOAD.
- LOAD (1 cycle): i_mem_data = ram[o_addr]. At the closing edge: o_data<=i_mem_data, o_stb<=1 -> SEND.
- SEND: o_stb=1; o_data and o_addr held constant while i_busy=1, for any number of cycles. On the acceptance edge (i_busy=0):
  - o_stb<=0.
  - If o_addr != MSG_LEN-1: o_addr<=o_addr+1 -> FETCH.
  - Else: o_addr<=0, o_done<=1 for exactly one cycle. Then -> PAUSE, with the counter loaded with PAUSE_CYCLES-1, if PAUSE_CYCLES>0. Otherwise -> FETCH if i_en=1, else IDLE.
- PAUSE: the counter decrements each cycle. When it reaches 0 -> FETCH if i_en=1, else IDLE.
- Latency: o_stb rises on the 3rd rising edge counting the edge that sampled i_en=1 in IDLE. Between bytes, o_stb is low for exactly 2 cycles (FETCH, LOAD). Best-case throughput is 1 byte per 3 cycles.
- Deasserting i_en mid-pass does not abort; the current pass completes, including the pause.
- o_stb never rises while o_stb=1; no byte is skipped or duplicated.
- Address wraps only via the MSG_LEN-1 -> 0 rule. With MSG_LEN=(1<<W), that is the natural wrap.
- o_addr is never outside 0..MSG_LEN-1.
- i_busy is ignored outside SEND. o_data retains the last sent byte when o_stb=0.
- Formal properties:
  - o_stb implies state==SEND.
  - $stable(o_data) while $past(o_stb && i_busy).
  - o_addr<MSG_LEN.
  - o_done implies $past(o_stb && !i_busy && o_addr==MSG_LEN-1).

Test Plan:
(Bench uses W=4, DW=8, MSG_LEN=3, PAUSE_CYCLES=2; the memory model holds 0x41,0x42,0x43 at 0..2 with 1-cycle registered read; i_busy=0 unless stated.)
1. Reset, then i_en=1 held -> o_stb pulses carry 0x41,0x42,0x43 with o_stb high on cycles 3, 6, 9 after i_en was sampled. o_done pulses with the 0x43 acceptance. 2 PAUSE cycles follow, then 0x41 repeats.
2. i_busy=1 for 5 cycles during byte 0x42 -> o_stb stays high and o_data=0x42 stable for 6 cycles. Accepted exactly once; next byte is 0x43.
3. i_en pulsed for 1 cycle in IDLE, then held 0 -> exactly 0x41,0x42,0x43 sent, one o_done, then return to IDLE with o_active=0 and o_addr=0.
4. i_reset_n asserted while in SEND with o_data=0x42 and i_busy=1 -> o_stb=0, o_addr=0, o_active=0 immediately without a clock edge. After release with i_en=1, streaming restarts at 0x41.
5. PAUSE_CYCLES=0, MSG_LEN=1 -> continuous 0x41 bytes with o_done on every acceptance and o_addr constant 0.
6. Random i_busy (50%) over 100 bytes -> received sequence equals 0x41,0x42,0x43 repeating, with no drops and no duplicates.
